// File: rtl/ibex_pkg.sv
// Shared types and defaults for the instruction-fetch align FIFO.
package ibex_pkg;

  localparam int unsigned FETCH_FIFO_DEPTH_DEFAULT = 3;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } fetch_entry_t;

  // A halfword starts a compressed instruction unless its two LSBs are 2'b11.
  function automatic logic is_compressed(input logic [1:0] lsb);
    return lsb != 2'b11;
  endfunction

endpackage

// File: rtl/ibex_fetch_align_fifo_if.sv
// Memory-response input and aligned-instruction output of the fetch FIFO.
interface ibex_fetch_align_fifo_if;
  logic        in_valid_i;
  logic [31:0] in_rdata_i;
  logic        in_err_i;
  logic        busy_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_err_o;
  logic        out_err_plus2_o;

  modport master (
    output in_valid_i, in_rdata_i, in_err_i, out_ready_i,
    input  busy_o, out_valid_o, out_rdata_o, out_addr_o, out_err_o, out_err_plus2_o
  );

  modport slave (
    input  in_valid_i, in_rdata_i, in_err_i, out_ready_i,
    output busy_o, out_valid_o, out_rdata_o, out_addr_o, out_err_o, out_err_plus2_o
  );
endinterface

// File: rtl/ibex_fetch_realign.sv
// Combinational realignment of the two head words into one instruction.
module ibex_fetch_realign
  import ibex_pkg::*;
(
  input  fetch_entry_t i_e0,
  input  logic         i_e0_valid,
  input  logic [15:0]  i_e1_lo,
  input  logic         i_e1_err,
  input  logic         i_e1_valid,
  input  logic         i_pc_hi,
  output logic [31:0]  o_rdata,
  output logic         o_valid,
  output logic         o_err,
  output logic         o_err_plus2,
  output logic         o_compressed,
  output logic         o_pop
);

  logic w_lo_c;
  logic w_hi_c;

  assign w_lo_c = is_compressed(i_e0.rdata[1:0]);
  assign w_hi_c = is_compressed(i_e0.rdata[17:16]);

  always_comb begin
    o_rdata      = i_e0.rdata;
    o_valid      = i_e0_valid;
    o_err        = i_e0.err;
    o_err_plus2  = 1'b0;
    o_compressed = 1'b0;
    o_pop        = 1'b1;
    if (!i_pc_hi) begin
      o_compressed = w_lo_c;
      o_pop        = !w_lo_c;
      if (w_lo_c) o_rdata = {16'h0, i_e0.rdata[15:0]};
    end else if (w_hi_c) begin
      o_compressed = 1'b1;
      o_rdata      = {16'h0, i_e0.rdata[31:16]};
    end else begin
      // Straddle: an errored first word is released without waiting for the second.
      o_rdata     = {i_e1_lo, i_e0.rdata[31:16]};
      o_valid     = i_e0_valid & (i_e1_valid | i_e0.err);
      o_err       = i_e0.err | (i_e1_valid & i_e1_err);
      o_err_plus2 = !i_e0.err & i_e1_valid & i_e1_err;
    end
  end

endmodule

// File: rtl/ibex_fetch_align_fifo.sv
// Fetch buffer realigning word responses into instructions.
// Optional same-cycle bypass from an empty FIFO: IBEX_FETCH_FIFO_BYPASS_EN.
module ibex_fetch_align_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_FIFO_DEPTH_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic [31:0]          clear_addr_i,
  ibex_fetch_align_fifo_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t      r_entries [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_pc;

  fetch_entry_t      w_entries_nxt [DEPTH];
  logic [DEPTH-1:0]  w_valid_nxt;
  logic [CNT_W-1:0]  w_wr_idx;
  fetch_entry_t      w_in;
  fetch_entry_t      w_e0;
  logic              w_v0;
  logic [31:0]       w_rdata;
  logic              w_valid;
  logic              w_err;
  logic              w_err_plus2;
  logic              w_compressed;
  logic              w_pop_flag;
  logic              w_consume;
  logic              w_pop_req;
  logic              w_pop;
  logic              w_push;

  assign w_in = '{rdata: bus.in_rdata_i, err: bus.in_err_i};

`ifdef IBEX_FETCH_FIFO_BYPASS_EN
  logic w_bypass;
  assign w_bypass = (r_count == '0) & bus.in_valid_i & ~clear_i &
                    (~r_pc[1] | is_compressed(bus.in_rdata_i[17:16]) | bus.in_err_i);
  assign w_e0   = w_bypass ? w_in : r_entries[0];
  assign w_v0   = w_bypass | r_valid[0];
  assign w_pop  = w_pop_req & ~w_bypass;
  assign w_push = bus.in_valid_i & ~clear_i & ~(w_bypass & w_pop_req);
`else
  assign w_e0   = r_entries[0];
  assign w_v0   = r_valid[0];
  assign w_pop  = w_pop_req;
  assign w_push = bus.in_valid_i & ~clear_i;
`endif

  ibex_fetch_realign u_realign (
    .i_e0         (w_e0),
    .i_e0_valid   (w_v0),
    .i_e1_lo      (r_entries[1].rdata[15:0]),
    .i_e1_err     (r_entries[1].err),
    .i_e1_valid   (r_valid[1]),
    .i_pc_hi      (r_pc[1]),
    .o_rdata      (w_rdata),
    .o_valid      (w_valid),
    .o_err        (w_err),
    .o_err_plus2  (w_err_plus2),
    .o_compressed (w_compressed),
    .o_pop        (w_pop_flag)
  );

  assign w_consume = w_valid & bus.out_ready_i;
  assign w_pop_req = w_consume & w_pop_flag;

  // Shift on pop, then write the incoming word behind the last valid entry.
  always_comb begin
    w_entries_nxt = r_entries;
    w_valid_nxt   = r_valid;
    w_wr_idx      = r_count - CNT_W'(w_pop);
    if (w_pop) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        w_entries_nxt[i] = r_entries[i+1];
        w_valid_nxt[i]   = r_valid[i+1];
      end
      w_valid_nxt[DEPTH-1] = 1'b0;
    end
    if (w_push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == w_wr_idx) begin
          w_entries_nxt[i] = w_in;
          w_valid_nxt[i]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      r_valid <= '0;
      r_count <= '0;
      r_pc    <= '0;
    end else if (clear_i) begin
      r_valid <= '0;
      r_count <= '0;
      r_pc    <= clear_addr_i & ~32'h1;
    end else begin
      r_entries <= w_entries_nxt;
      r_valid   <= w_valid_nxt;
      r_count   <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_consume) r_pc <= r_pc + (w_compressed ? 32'd2 : 32'd4);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(w_push && !w_pop && r_count == CNT_W'(DEPTH)))
        else $error("push into full fetch fifo");
    end
  end

  assign bus.busy_o          = r_count >= CNT_W'(DEPTH - 1);
  assign bus.out_valid_o     = w_valid;
  assign bus.out_rdata_o     = w_rdata;
  assign bus.out_addr_o      = r_pc;
  assign bus.out_err_o       = w_err;
  assign bus.out_err_plus2_o = w_err_plus2;

endmodule

// File: tb/tb_ibex_fetch_align_fifo.sv
// Directed and randomized checks of the fetch align FIFO against a halfword-stream model.
module tb_ibex_fetch_align_fifo;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        clear_i;
  logic [31:0] clear_addr_i;

  ibex_fetch_align_fifo_if bus();

  ibex_fetch_align_fifo dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .clear_addr_i (clear_addr_i),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] hwq[$];
  logic [31:0] pc_m;
  bit          skip_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the fetch stream is a sequence of halfwords starting at the PC.
  task automatic model_extract();
    logic [15:0] h0;
    exp_t e;
    forever begin
      if (hwq.size() == 0) break;
      h0 = hwq[0];
      if (h0[1:0] != 2'b11) begin
        e.addr = pc_m; e.data = {16'h0, h0};
        void'(hwq.pop_front());
        pc_m = pc_m + 32'd2;
      end else if (hwq.size() >= 2) begin
        e.addr = pc_m; e.data = {hwq[1], h0};
        void'(hwq.pop_front());
        void'(hwq.pop_front());
        pc_m = pc_m + 32'd4;
      end else break;
      expq.push_back(e);
    end
  endtask

  task automatic model_step();
    if (rst_i) begin
      pc_m = 32'h0; hwq.delete(); expq.delete(); skip_lo = 1'b0;
    end else if (clear_i) begin
      pc_m = clear_addr_i & ~32'h1;
      hwq.delete(); expq.delete();
      skip_lo = pc_m[1];
    end else if (bus.in_valid_i) begin
      if (!skip_lo) hwq.push_back(bus.in_rdata_i[15:0]);
      hwq.push_back(bus.in_rdata_i[31:16]);
      skip_lo = 1'b0;
      model_extract();
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: valid must track model availability; each accepted instruction is scored.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mon_en && !rst_i) begin
      chk("valid", 32'(bus.out_valid_o), 32'(expq.size() != 0));
      if (bus.out_valid_o && bus.out_ready_i && expq.size() != 0) begin
        e = expq.pop_front();
        chk("addr", bus.out_addr_o, e.addr);
        chk("rdata", bus.out_rdata_o, e.data);
        chk("err", 32'(bus.out_err_o), 32'd0);
      end
    end
  end

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
    if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
    return w;
  endfunction

  task automatic do_clear(input logic [31:0] a);
    clear_i = 1'b1; clear_addr_i = a;
    step();
    clear_i = 1'b0;
  endtask

  task automatic push(input logic [31:0] w, input logic e);
    bus.in_valid_i = 1'b1; bus.in_rdata_i = w; bus.in_err_i = e;
    step();
    bus.in_valid_i = 1'b0; bus.in_err_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; clear_addr_i = '0;
    bus.in_valid_i = 1'b0; bus.in_rdata_i = '0; bus.in_err_i = 1'b0; bus.out_ready_i = 1'b0;
    step(); step();
    chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_addr", bus.out_addr_o, 32'd0);
    chk("rst_rdata", bus.out_rdata_o, 32'd0);
    chk("rst_err", 32'(bus.out_err_o), 32'd0);
    chk("rst_errp2", 32'(bus.out_err_plus2_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    rst_i = 1'b0;
    step();

    // Aligned uncompressed
    do_clear(32'h80);
    push(32'h00500093, 1'b0);
    chk("al_valid", 32'(bus.out_valid_o), 32'd1);
    chk("al_addr", bus.out_addr_o, 32'h80);
    chk("al_rdata", bus.out_rdata_o, 32'h00500093);
    bus.out_ready_i = 1'b1; step(); bus.out_ready_i = 1'b0;
    chk("al_addr2", bus.out_addr_o, 32'h84);
    chk("al_empty", 32'(bus.out_valid_o), 32'd0);

    // Two compressed in one word
    do_clear(32'h100);
    push(32'h40814505, 1'b0);
    chk("c2_rdata0", bus.out_rdata_o, 32'h00004505);
    chk("c2_addr0", bus.out_addr_o, 32'h100);
    bus.out_ready_i = 1'b1; step();
    chk("c2_valid1", 32'(bus.out_valid_o), 32'd1);
    chk("c2_rdata1", bus.out_rdata_o, 32'h00004081);
    chk("c2_addr1", bus.out_addr_o, 32'h102);
    step(); bus.out_ready_i = 1'b0;
    chk("c2_empty", 32'(bus.out_valid_o), 32'd0);
    chk("c2_addr2", bus.out_addr_o, 32'h104);

    // Straddle across a word boundary, held stable while not ready
    do_clear(32'h202);
    push(32'h12371111, 1'b0);
    chk("st_wait", 32'(bus.out_valid_o), 32'd0);
    push(32'h00005678, 1'b0);
    chk("st_valid", 32'(bus.out_valid_o), 32'd1);
    chk("st_rdata", bus.out_rdata_o, 32'h56781237);
    chk("st_addr", bus.out_addr_o, 32'h202);
    step();
    chk("st_hold", bus.out_rdata_o, 32'h56781237);
    bus.out_ready_i = 1'b1; step(); bus.out_ready_i = 1'b0;
    chk("st_addr2", bus.out_addr_o, 32'h206);

    // Error only in the second word of a straddle
    do_clear(32'h302);
    push(32'hABCF0001, 1'b0);
    push(32'h00001111, 1'b1);
    chk("e2_valid", 32'(bus.out_valid_o), 32'd1);
    chk("e2_rdata", bus.out_rdata_o, 32'h1111ABCF);
    chk("e2_err", 32'(bus.out_err_o), 32'd1);
    chk("e2_errp2", 32'(bus.out_err_plus2_o), 32'd1);

    // Errored first word of a straddle is released alone
    do_clear(32'h503);
    push(32'hFFFF0000, 1'b1);
    chk("e1_addr", bus.out_addr_o, 32'h502);
    chk("e1_valid", 32'(bus.out_valid_o), 32'd1);
    chk("e1_err", 32'(bus.out_err_o), 32'd1);
    chk("e1_errp2", 32'(bus.out_err_plus2_o), 32'd0);

    // Fill then flush with a dropped same-cycle push
    do_clear(32'h0);
    push(32'h00000013, 1'b0);
    chk("f_busy1", 32'(bus.busy_o), 32'd0);
    push(32'h00000013, 1'b0);
    push(32'h00000013, 1'b0);
    chk("f_busy3", 32'(bus.busy_o), 32'd1);
    bus.in_valid_i = 1'b1; bus.in_rdata_i = 32'hDEADBEEF;
    do_clear(32'h400);
    bus.in_valid_i = 1'b0;
    chk("f_valid", 32'(bus.out_valid_o), 32'd0);
    chk("f_addr", bus.out_addr_o, 32'h400);
    chk("f_busy", 32'(bus.busy_o), 32'd0);
    push(32'h00100073, 1'b0);
    chk("f_rdata", bus.out_rdata_o, 32'h00100073);

    // PC wrap
    do_clear(32'hFFFFFFFC);
    push(32'h00010001, 1'b0);
    push(32'h00010001, 1'b0);
    chk("w_addr0", bus.out_addr_o, 32'hFFFFFFFC);
    bus.out_ready_i = 1'b1; step();
    chk("w_addr1", bus.out_addr_o, 32'hFFFFFFFE);
    step();
    chk("w_addr2", bus.out_addr_o, 32'h00000000);
    chk("w_rdata2", bus.out_rdata_o, 32'h00000001);
    bus.out_ready_i = 1'b0;

    // Randomized traffic against the stream model
    do_clear(32'h1000);
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      clear_i      = ($urandom_range(0, 59) == 0);
      clear_addr_i = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hF)) : $urandom;
      bus.in_valid_i  = !bus.busy_o && ($urandom_range(0, 3) != 0);
      bus.in_rdata_i  = rand_word();
      bus.in_err_i    = 1'b0;
      bus.out_ready_i = ($urandom_range(0, 2) != 0);
      step();
    end
    clear_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    for (int c = 0; c < 20; c++) step();
    chk("drain", 32'(expq.size()), 32'd0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
